collision_detector: RTL and testbench

COLLISION_DETECTOR -- requirements
Module: collision_detector

---
 rtl/game_pkg.sv | 44 ++++
 rtl/box_overlap.sv | 37 +++
 rtl/collision_detector.sv | 236 +++++++++++++++++++++++
 tb/tb_collision_detector.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants: entity record layout, slot counts, box sizes and the
// collision scan state type.
package game_pkg;

  localparam int ENTITY_SIZE   = 34;
  localparam int MAX_SHOTS     = 3;
  localparam int MAX_ASTEROIDS = 4;
  localparam int ASTEROID_SIZE = 16;
  localparam int SHIP_SIZE     = 8;

  localparam int DIR_LSB    = 0;
  localparam int DIR_MSB    = 5;
  localparam int X_LSB      = 6;
  localparam int X_MSB      = 15;
  localparam int Y_LSB      = 16;
  localparam int Y_MSB      = 25;
  localparam int ACTIVE_BIT = 33;

  localparam int DIR_W   = DIR_MSB - DIR_LSB + 1;
  localparam int PAD_W   = ACTIVE_BIT - Y_MSB - 1;
  localparam int COORD_W = X_MSB - X_LSB + 1;
  // One extra bit so that coordinate + box size can never wrap.
  localparam int CMP_W   = COORD_W + 1;
  localparam int IDX_W   = 2;
  localparam int COUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHOT_SCAN,
    SHIP_SCAN,
    DONE
  } scan_state_e;

  typedef struct packed {
    logic               active;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } coord_t;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
    return (value == {COUNT_W{1'b1}}) ? value : value + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/box_overlap.sv
// Axis-aligned overlap of box A (side A_SIZE) and box B (side B_SIZE).
// A point inside a box is simply the B_SIZE = 1 case.
module box_overlap
  import game_pkg::*;
#(
  parameter int A_SIZE = ASTEROID_SIZE,
  parameter int B_SIZE = 1
) (
  input  logic [COORD_W-1:0] a_x_i,
  input  logic [COORD_W-1:0] a_y_i,
  input  logic [COORD_W-1:0] b_x_i,
  input  logic [COORD_W-1:0] b_y_i,
  output logic               overlap_o
);

  logic [CMP_W-1:0] ax;
  logic [CMP_W-1:0] ay;
  logic [CMP_W-1:0] bx;
  logic [CMP_W-1:0] by;
  logic [CMP_W-1:0] a_x_end;
  logic [CMP_W-1:0] a_y_end;
  logic [CMP_W-1:0] b_x_end;
  logic [CMP_W-1:0] b_y_end;

  assign ax      = {1'b0, a_x_i};
  assign ay      = {1'b0, a_y_i};
  assign bx      = {1'b0, b_x_i};
  assign by      = {1'b0, b_y_i};
  assign a_x_end = ax + CMP_W'(A_SIZE);
  assign a_y_end = ay + CMP_W'(A_SIZE);
  assign b_x_end = bx + CMP_W'(B_SIZE);
  assign b_y_end = by + CMP_W'(B_SIZE);

  assign overlap_o = (bx < a_x_end) && (ax < b_x_end) &&
                     (by < a_y_end) && (ay < b_y_end);

endmodule

// File: rtl/collision_detector.sv
// Sequential collision scanner: walks every (shot, asteroid) pair and then
// (ship, asteroid) pair on a snapshot of the game state, one pair per cycle.
module collision_detector #(
  parameter int ENTITY_SIZE   = game_pkg::ENTITY_SIZE,
  parameter int MAX_SHOTS     = game_pkg::MAX_SHOTS,
  parameter int MAX_ASTEROIDS = game_pkg::MAX_ASTEROIDS,
  parameter int ASTEROID_SIZE = game_pkg::ASTEROID_SIZE,
  parameter int SHIP_SIZE     = game_pkg::SHIP_SIZE
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic [ENTITY_SIZE-1:0]              ship,
  input  logic [MAX_SHOTS*ENTITY_SIZE-1:0]    shots,
  input  logic [MAX_ASTEROIDS*ENTITY_SIZE-1:0] asteroids,
  output logic                                busy,
  output logic                                done,
  output logic                                delete_shot,
  output logic [1:0]                          shot_address,
  output logic                                delete_asteroid,
  output logic [1:0]                          asteroid_address,
  output logic                                ship_hit,
  output logic [7:0]                          hit_count
);

  import game_pkg::*;

  localparam logic [IDX_W-1:0] LAST_SHOT = IDX_W'(MAX_SHOTS - 1);
  localparam logic [IDX_W-1:0] LAST_AST  = IDX_W'(MAX_ASTEROIDS - 1);

  scan_state_e state_q, state_d;

  coord_t ship_dec;
  coord_t shot_dec [MAX_SHOTS];
  coord_t ast_dec  [MAX_ASTEROIDS];
  coord_t ship_q;
  coord_t shot_q   [MAX_SHOTS];
  coord_t ast_q    [MAX_ASTEROIDS];
  coord_t cur_shot;
  coord_t cur_ast;

  logic [MAX_SHOTS+MAX_ASTEROIDS:0] unused_fields;

  logic [IDX_W-1:0]         shot_idx_q, shot_idx_d;
  logic [IDX_W-1:0]         ast_idx_q, ast_idx_d;
  logic [MAX_SHOTS-1:0]     shot_kill_q, shot_kill_d;
  logic [MAX_ASTEROIDS-1:0] ast_kill_q, ast_kill_d;
  logic                     load_snap;
  logic                     shot_overlap;
  logic                     ship_overlap;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               del_shot_q, del_shot_d;
  logic               del_ast_q, del_ast_d;
  logic               ship_hit_q, ship_hit_d;
  logic [IDX_W-1:0]   shot_addr_q, shot_addr_d;
  logic [IDX_W-1:0]   ast_addr_q, ast_addr_d;
  logic [COUNT_W-1:0] hit_count_q, hit_count_d;

  // Pull only position and active flag out of each record; direction and
  // the spare bits are folded into a deliberately unused signal.
  always_comb begin
    ship_dec.active  = ship[ACTIVE_BIT];
    ship_dec.y       = ship[Y_MSB:Y_LSB];
    ship_dec.x       = ship[X_MSB:X_LSB];
    unused_fields    = '0;
    unused_fields[0] = ^{ship[ACTIVE_BIT-1:Y_MSB+1], ship[DIR_MSB:DIR_LSB]};
    for (int s = 0; s < MAX_SHOTS; s++) begin
      shot_dec[s].active = shots[s*ENTITY_SIZE + ACTIVE_BIT];
      shot_dec[s].y      = shots[s*ENTITY_SIZE + Y_LSB +: COORD_W];
      shot_dec[s].x      = shots[s*ENTITY_SIZE + X_LSB +: COORD_W];
      unused_fields[1+s] = ^{shots[s*ENTITY_SIZE + Y_MSB + 1 +: PAD_W],
                             shots[s*ENTITY_SIZE + DIR_LSB +: DIR_W]};
    end
    for (int a = 0; a < MAX_ASTEROIDS; a++) begin
      ast_dec[a].active = asteroids[a*ENTITY_SIZE + ACTIVE_BIT];
      ast_dec[a].y      = asteroids[a*ENTITY_SIZE + Y_LSB +: COORD_W];
      ast_dec[a].x      = asteroids[a*ENTITY_SIZE + X_LSB +: COORD_W];
      unused_fields[1+MAX_SHOTS+a] = ^{asteroids[a*ENTITY_SIZE + Y_MSB + 1 +: PAD_W],
                                       asteroids[a*ENTITY_SIZE + DIR_LSB +: DIR_W]};
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      ship_q <= '0;
      shot_q <= '{default: '0};
      ast_q  <= '{default: '0};
    end else if (load_snap) begin
      ship_q <= ship_dec;
      shot_q <= shot_dec;
      ast_q  <= ast_dec;
    end
  end

  assign cur_shot = shot_q[shot_idx_q];
  assign cur_ast  = ast_q[ast_idx_q];

  box_overlap #(
    .A_SIZE(ASTEROID_SIZE),
    .B_SIZE(1)
  ) u_shot_box (
    .a_x_i    (cur_ast.x),
    .a_y_i    (cur_ast.y),
    .b_x_i    (cur_shot.x),
    .b_y_i    (cur_shot.y),
    .overlap_o(shot_overlap)
  );

  box_overlap #(
    .A_SIZE(ASTEROID_SIZE),
    .B_SIZE(SHIP_SIZE)
  ) u_ship_box (
    .a_x_i    (cur_ast.x),
    .a_y_i    (cur_ast.y),
    .b_x_i    (ship_q.x),
    .b_y_i    (ship_q.y),
    .overlap_o(ship_overlap)
  );

  // Kill masks are consulted before the pair is evaluated, so the first shot
  // to reach an asteroid owns it and later pairs involving either are skipped.
  always_comb begin
    state_d     = state_q;
    shot_idx_d  = shot_idx_q;
    ast_idx_d   = ast_idx_q;
    shot_kill_d = shot_kill_q;
    ast_kill_d  = ast_kill_q;
    load_snap   = 1'b0;
    done_d      = 1'b0;
    del_shot_d  = 1'b0;
    del_ast_d   = 1'b0;
    ship_hit_d  = 1'b0;
    shot_addr_d = shot_addr_q;
    ast_addr_d  = ast_addr_q;
    hit_count_d = hit_count_q;

    case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          load_snap   = 1'b1;
          shot_kill_d = '0;
          ast_kill_d  = '0;
          shot_idx_d  = '0;
          ast_idx_d   = '0;
          state_d     = SHOT_SCAN;
        end
      end
      SHOT_SCAN: begin
        if (cur_shot.active && cur_ast.active && shot_overlap &&
            !shot_kill_q[shot_idx_q] && !ast_kill_q[ast_idx_q]) begin
          del_shot_d              = 1'b1;
          del_ast_d               = 1'b1;
          shot_addr_d             = shot_idx_q;
          ast_addr_d              = ast_idx_q;
          shot_kill_d[shot_idx_q] = 1'b1;
          ast_kill_d[ast_idx_q]   = 1'b1;
          hit_count_d             = sat_inc(hit_count_q);
        end
        if (ast_idx_q == LAST_AST) begin
          ast_idx_d = '0;
          if (shot_idx_q == LAST_SHOT) begin
            shot_idx_d = '0;
            state_d    = SHIP_SCAN;
          end else begin
            shot_idx_d = shot_idx_q + IDX_W'(1);
          end
        end else begin
          ast_idx_d = ast_idx_q + IDX_W'(1);
        end
      end
      SHIP_SCAN: begin
        if (ship_q.active && cur_ast.active && ship_overlap && !ast_kill_q[ast_idx_q]) begin
          ship_hit_d = 1'b1;
        end
        if (ast_idx_q == LAST_AST) begin
          ast_idx_d = '0;
          state_d   = DONE;
        end else begin
          ast_idx_d = ast_idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Busy stays up through the cycle in which the registered done is high.
    busy_d = (state_d != IDLE) || (state_q == DONE);
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q     <= IDLE;
      shot_idx_q  <= '0;
      ast_idx_q   <= '0;
      shot_kill_q <= '0;
      ast_kill_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      del_shot_q  <= 1'b0;
      del_ast_q   <= 1'b0;
      ship_hit_q  <= 1'b0;
      shot_addr_q <= '0;
      ast_addr_q  <= '0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      shot_idx_q  <= shot_idx_d;
      ast_idx_q   <= ast_idx_d;
      shot_kill_q <= shot_kill_d;
      ast_kill_q  <= ast_kill_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      del_shot_q  <= del_shot_d;
      del_ast_q   <= del_ast_d;
      ship_hit_q  <= ship_hit_d;
      shot_addr_q <= shot_addr_d;
      ast_addr_q  <= ast_addr_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign delete_shot      = del_shot_q;
  assign shot_address     = shot_addr_q;
  assign delete_asteroid  = del_ast_q;
  assign asteroid_address = ast_addr_q;
  assign ship_hit         = ship_hit_q;
  assign hit_count        = hit_count_q;

endmodule

// File: tb/tb_collision_detector.sv
// Directed bench for collision_detector: each scan is recorded cycle by cycle
// after start and compared against hand-derived pulse positions.
module tb_collision_detector;

  localparam int ES  = 34;
  localparam int WIN = 21;
  localparam logic [WIN-1:0] ONE      = 1;
  localparam logic [WIN-1:0] NONE     = '0;
  localparam logic [WIN-1:0] BUSY_EXP = (ONE << 18) - ONE;
  localparam logic [WIN-1:0] DONE_EXP = ONE << 17;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [ES-1:0]   ship;
  logic [3*ES-1:0] shots;
  logic [4*ES-1:0] asteroids;
  logic          busy, done, delete_shot, delete_asteroid, ship_hit;
  logic [1:0]    shot_address, asteroid_address;
  logic [7:0]    hit_count;

  int checks = 0;
  int fails  = 0;

  logic [WIN-1:0] rec_busy, rec_done, rec_ds, rec_da, rec_sh;
  logic [1:0]     rec_sa [WIN];
  logic [1:0]     rec_aa [WIN];

  always #5 clk = ~clk;

  collision_detector dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .ship            (ship),
    .shots           (shots),
    .asteroids       (asteroids),
    .busy            (busy),
    .done            (done),
    .delete_shot     (delete_shot),
    .shot_address    (shot_address),
    .delete_asteroid (delete_asteroid),
    .asteroid_address(asteroid_address),
    .ship_hit        (ship_hit),
    .hit_count       (hit_count)
  );

  function automatic logic [ES-1:0] ent(input logic act, input int x, input int y);
    logic [9:0] xv;
    logic [9:0] yv;
    xv = x[9:0];
    yv = y[9:0];
    return {act, 7'h55, yv, xv, 6'h2A};
  endfunction

  task automatic clear_entities();
    ship      = '0;
    shots     = '0;
    asteroids = '0;
  endtask

  task automatic set_shot(input int idx, input logic [ES-1:0] r);
    shots[idx*ES +: ES] = r;
  endtask

  task automatic set_ast(input int idx, input logic [ES-1:0] r);
    asteroids[idx*ES +: ES] = r;
  endtask

  task automatic apply_reset();
    start   = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic sample(input int c);
    rec_busy[c] = busy;
    rec_done[c] = done;
    rec_ds[c]   = delete_shot;
    rec_da[c]   = delete_asteroid;
    rec_sh[c]   = ship_hit;
    rec_sa[c]   = shot_address;
    rec_aa[c]   = asteroid_address;
  endtask

  // Index c of the records holds the outputs of the cycle following edge k+c.
  task automatic do_scan();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sample(0);
    for (int c = 1; c < WIN; c++) begin
      @(negedge clk);
      sample(c);
    end
  endtask

  task automatic test_reset();
    start = 1'b0;
    clear_entities();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset done: got %b expected 0", done); end
    checks++; if (delete_shot !== 1'b0) begin fails++; $display("[TB] FAIL reset delete_shot: got %b expected 0", delete_shot); end
    checks++; if (delete_asteroid !== 1'b0) begin fails++; $display("[TB] FAIL reset delete_asteroid: got %b expected 0", delete_asteroid); end
    checks++; if (ship_hit !== 1'b0) begin fails++; $display("[TB] FAIL reset ship_hit: got %b expected 0", ship_hit); end
    checks++; if (shot_address !== 2'd0) begin fails++; $display("[TB] FAIL reset shot_address: got %0d expected 0", shot_address); end
    checks++; if (asteroid_address !== 2'd0) begin fails++; $display("[TB] FAIL reset asteroid_address: got %0d expected 0", asteroid_address); end
    checks++; if (hit_count !== 8'd0) begin fails++; $display("[TB] FAIL reset hit_count: got %0d expected 0", hit_count); end
    reset_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_hit();
    apply_reset();
    clear_entities();
    set_shot(0, ent(1'b1, 105, 205));
    set_ast(2, ent(1'b1, 100, 200));
    do_scan();
    checks++; if (rec_ds !== (ONE << 3)) begin fails++; $display("[TB] FAIL single_hit delete_shot: got %b expected %b", rec_ds, ONE << 3); end
    checks++; if (rec_da !== (ONE << 3)) begin fails++; $display("[TB] FAIL single_hit delete_asteroid: got %b expected %b", rec_da, ONE << 3); end
    checks++; if (rec_sa[3] !== 2'd0) begin fails++; $display("[TB] FAIL single_hit shot_address: got %0d expected 0", rec_sa[3]); end
    checks++; if (rec_aa[3] !== 2'd2) begin fails++; $display("[TB] FAIL single_hit asteroid_address: got %0d expected 2", rec_aa[3]); end
    checks++; if (rec_sh !== NONE) begin fails++; $display("[TB] FAIL single_hit ship_hit: got %b expected %b", rec_sh, NONE); end
    checks++; if (rec_done !== DONE_EXP) begin fails++; $display("[TB] FAIL single_hit done: got %b expected %b", rec_done, DONE_EXP); end
    checks++; if (rec_busy !== BUSY_EXP) begin fails++; $display("[TB] FAIL single_hit busy: got %b expected %b", rec_busy, BUSY_EXP); end
    checks++; if (hit_count !== 8'd1) begin fails++; $display("[TB] FAIL single_hit hit_count: got %0d expected 1", hit_count); end
  endtask

  task automatic test_first_shot_wins();
    apply_reset();
    clear_entities();
    set_shot(0, ent(1'b1, 103, 103));
    set_shot(1, ent(1'b1, 110, 110));
    set_ast(0, ent(1'b1, 100, 100));
    do_scan();
    checks++; if (rec_ds !== (ONE << 1)) begin fails++; $display("[TB] FAIL first_shot delete_shot: got %b expected %b", rec_ds, ONE << 1); end
    checks++; if (rec_da !== (ONE << 1)) begin fails++; $display("[TB] FAIL first_shot delete_asteroid: got %b expected %b", rec_da, ONE << 1); end
    checks++; if (rec_sa[1] !== 2'd0 || rec_aa[1] !== 2'd0) begin fails++; $display("[TB] FAIL first_shot addresses: got %0d/%0d expected 0/0", rec_sa[1], rec_aa[1]); end
    checks++; if (hit_count !== 8'd1) begin fails++; $display("[TB] FAIL first_shot hit_count: got %0d expected 1", hit_count); end
  endtask

  task automatic test_boundaries();
    apply_reset();
    clear_entities();
    set_shot(0, ent(1'b1, 115, 100));
    set_shot(1, ent(1'b1, 216, 200));
    set_shot(2, ent(1'b1, 200, 215));
    set_ast(0, ent(1'b1, 100, 100));
    set_ast(1, ent(1'b1, 200, 200));
    do_scan();
    checks++; if (rec_ds !== ((ONE << 1) | (ONE << 10))) begin fails++; $display("[TB] FAIL boundary delete_shot: got %b expected %b", rec_ds, (ONE << 1) | (ONE << 10)); end
    checks++; if (rec_sa[1] !== 2'd0 || rec_aa[1] !== 2'd0) begin fails++; $display("[TB] FAIL boundary first addresses: got %0d/%0d expected 0/0", rec_sa[1], rec_aa[1]); end
    checks++; if (rec_sa[10] !== 2'd2 || rec_aa[10] !== 2'd1) begin fails++; $display("[TB] FAIL boundary second addresses: got %0d/%0d expected 2/1", rec_sa[10], rec_aa[10]); end
    checks++; if (rec_aa[12] !== 2'd1) begin fails++; $display("[TB] FAIL boundary address hold: got %0d expected 1", rec_aa[12]); end
    checks++; if (hit_count !== 8'd2) begin fails++; $display("[TB] FAIL boundary hit_count: got %0d expected 2", hit_count); end
  endtask

  task automatic test_ship();
    apply_reset();
    clear_entities();
    ship = ent(1'b1, 90, 90);
    set_ast(3, ent(1'b1, 97, 97));
    do_scan();
    checks++; if (rec_sh !== (ONE << 16)) begin fails++; $display("[TB] FAIL ship_overlap ship_hit: got %b expected %b", rec_sh, ONE << 16); end
    checks++; if (rec_ds !== NONE) begin fails++; $display("[TB] FAIL ship_overlap delete_shot: got %b expected %b", rec_ds, NONE); end
    ship = ent(1'b1, 92, 90);
    set_ast(3, ent(1'b1, 100, 90));
    do_scan();
    checks++; if (rec_sh !== NONE) begin fails++; $display("[TB] FAIL ship_touching ship_hit: got %b expected %b", rec_sh, NONE); end
    checks++; if (rec_done !== DONE_EXP) begin fails++; $display("[TB] FAIL ship_touching done: got %b expected %b", rec_done, DONE_EXP); end
  endtask

  task automatic test_no_wrap();
    apply_reset();
    clear_entities();
    set_ast(0, ent(1'b1, 1015, 0));
    set_shot(0, ent(1'b1, 5, 5));
    set_shot(1, ent(1'b0, 105, 105));
    set_ast(1, ent(1'b1, 100, 100));
    set_shot(2, ent(1'b1, 1020, 5));
    set_ast(2, ent(1'b1, 1015, 500));
    ship = ent(1'b1, 1020, 505);
    do_scan();
    checks++; if (rec_ds !== (ONE << 9)) begin fails++; $display("[TB] FAIL no_wrap delete_shot: got %b expected %b", rec_ds, ONE << 9); end
    checks++; if (rec_sa[9] !== 2'd2 || rec_aa[9] !== 2'd0) begin fails++; $display("[TB] FAIL no_wrap addresses: got %0d/%0d expected 2/0", rec_sa[9], rec_aa[9]); end
    checks++; if (rec_sh !== (ONE << 15)) begin fails++; $display("[TB] FAIL no_wrap ship_hit: got %b expected %b", rec_sh, ONE << 15); end
    checks++; if (hit_count !== 8'd1) begin fails++; $display("[TB] FAIL no_wrap hit_count: got %0d expected 1", hit_count); end
  endtask

  task automatic test_saturation();
    apply_reset();
    clear_entities();
    set_shot(0, ent(1'b1, 105, 105));
    set_shot(1, ent(1'b1, 205, 205));
    set_shot(2, ent(1'b1, 305, 305));
    set_ast(0, ent(1'b1, 100, 100));
    set_ast(1, ent(1'b1, 200, 200));
    set_ast(2, ent(1'b1, 300, 300));
    repeat (84) do_scan();
    checks++; if (hit_count !== 8'd252) begin fails++; $display("[TB] FAIL saturation pre hit_count: got %0d expected 252", hit_count); end
    do_scan();
    checks++; if (rec_ds !== ((ONE << 1) | (ONE << 6) | (ONE << 11))) begin fails++; $display("[TB] FAIL saturation delete_shot: got %b expected %b", rec_ds, (ONE << 1) | (ONE << 6) | (ONE << 11)); end
    checks++; if (hit_count !== 8'd255) begin fails++; $display("[TB] FAIL saturation reach hit_count: got %0d expected 255", hit_count); end
    set_shot(1, ent(1'b0, 205, 205));
    set_shot(2, ent(1'b0, 305, 305));
    do_scan();
    checks++; if (rec_ds !== (ONE << 1)) begin fails++; $display("[TB] FAIL saturation extra delete_shot: got %b expected %b", rec_ds, ONE << 1); end
    checks++; if (hit_count !== 8'd255) begin fails++; $display("[TB] FAIL saturation hold hit_count: got %0d expected 255", hit_count); end
  endtask

  task automatic test_reset_mid_scan();
    logic seen_done;
    logic seen_pulse;
    logic seen_busy;
    apply_reset();
    clear_entities();
    set_shot(2, ent(1'b1, 305, 305));
    set_ast(3, ent(1'b1, 300, 300));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL mid_reset busy before: got %b expected 1", busy); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset busy after: got %b expected 0", busy); end
    reset_n = 1'b0;
    seen_done  = 1'b0;
    seen_pulse = 1'b0;
    seen_busy  = 1'b0;
    for (int c = 0; c < WIN; c++) begin
      @(negedge clk);
      seen_done  = seen_done | done;
      seen_pulse = seen_pulse | delete_shot | delete_asteroid | ship_hit;
      seen_busy  = seen_busy | busy;
    end
    checks++; if (seen_done !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset done after abort: got %b expected 0", seen_done); end
    checks++; if (seen_pulse !== 1'b0 || seen_busy !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset activity after abort: got pulse %b busy %b expected 0 0", seen_pulse, seen_busy); end
    do_scan();
    checks++; if (rec_done !== DONE_EXP) begin fails++; $display("[TB] FAIL mid_reset rescan done: got %b expected %b", rec_done, DONE_EXP); end
    checks++; if (rec_busy !== BUSY_EXP) begin fails++; $display("[TB] FAIL mid_reset rescan busy: got %b expected %b", rec_busy, BUSY_EXP); end
    checks++; if (rec_ds !== (ONE << 12)) begin fails++; $display("[TB] FAIL mid_reset rescan delete_shot: got %b expected %b", rec_ds, ONE << 12); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    clear_entities();
    set_shot(1, ent(1'b1, 405, 405));
    set_ast(3, ent(1'b1, 400, 400));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sample(0);
    for (int c = 1; c < WIN; c++) begin
      @(negedge clk);
      sample(c);
      if (c == 2) clear_entities();
      if (c == 5 || c == 17) start = 1'b1;
      if (c == 6 || c == 18) start = 1'b0;
    end
    checks++; if (rec_done !== DONE_EXP) begin fails++; $display("[TB] FAIL back_to_back done: got %b expected %b", rec_done, DONE_EXP); end
    checks++; if (rec_busy !== BUSY_EXP) begin fails++; $display("[TB] FAIL back_to_back busy: got %b expected %b", rec_busy, BUSY_EXP); end
    checks++; if (rec_ds !== (ONE << 8)) begin fails++; $display("[TB] FAIL back_to_back snapshot delete_shot: got %b expected %b", rec_ds, ONE << 8); end
    checks++; if (rec_sa[8] !== 2'd1 || rec_aa[8] !== 2'd3) begin fails++; $display("[TB] FAIL back_to_back addresses: got %0d/%0d expected 1/3", rec_sa[8], rec_aa[8]); end
  endtask

  initial begin
    reset_n = 1'b1;
    start   = 1'b0;
    clear_entities();
    test_reset();
    test_single_hit();
    test_first_shot_wins();
    test_boundaries();
    test_ship();
    test_no_wrap();
    test_saturation();
    test_reset_mid_scan();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
